// File: rtl/conv_stage_gen.sv
// conv_stage_gen: 3x3 stride-1 valid convolution over an IMG x IMG x CH map loaded from BRAM,
// streaming NFILT x OUT x OUT results. Define CONV_STAGE_RELU_EN to clamp results at zero.
module conv_stage_gen #(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned COEF_W = 17,
    parameter int unsigned IMG    = 8,
    parameter int unsigned CH     = 3,
    parameter int unsigned NFILT  = 4,
    localparam int unsigned OUT   = IMG - 2,
    localparam int unsigned NBUF  = IMG * IMG * CH,
    localparam int unsigned NTAP  = 9 * CH,
    localparam int unsigned NCOEF = NFILT * NTAP,
    localparam int unsigned ACC_W = DATA_W + 1 + COEF_W + $clog2(NTAP),
    localparam int unsigned AW    = (NBUF > 1) ? $clog2(NBUF) : 1,
    localparam int unsigned CW    = (NCOEF > 1) ? $clog2(NCOEF) : 1,
    localparam int unsigned FW    = (NFILT > 1) ? $clog2(NFILT) : 1,
    localparam int unsigned OW    = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     rd_en,
    output logic [AW-1:0]            rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    output logic [CW-1:0]            coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [FW-1:0]            out_filt,
    output logic [OW-1:0]            out_row,
    output logic [OW-1:0]            out_col,
    output logic                     done
);

    localparam int unsigned KW     = $clog2(NTAP + 1);
    localparam int unsigned CHW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PROD_W = DATA_W + 1 + COEF_W;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, FIN} state_t;

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d, rd_en_q, rd_en_d, done_q, done_d;
    logic [AW-1:0]             rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic                      wr_pend_q, wr_pend_d, tap_vld_q, tap_vld_d;
    logic [CW-1:0]             coef_addr_q, coef_addr_d;
    logic [KW-1:0]             kcnt_q, kcnt_d;
    logic [CHW-1:0]            ch_q, ch_d;
    logic [1:0]                kr_q, kr_d, kc_q, kc_d;
    logic [DATA_W-1:0]         act_q, act_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic [FW-1:0]             filt_q, filt_d;
    logic [OW-1:0]             row_q, row_d, col_q, col_d;

    logic [DATA_W-1:0]         mem_q [NBUF];

    logic [AW-1:0]             act_idx_c;
    logic signed [DATA_W:0]    act_s_c;
    logic signed [COEF_W-1:0]  coef_s_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   acc_sum_c, res_c;
    logic                      last_c;

    // Unsigned activation widened by a zero bit so the multiply stays signed.
    assign act_idx_c = AW'((32'(ch_q) * IMG + 32'(row_q) + 32'(kr_q)) * IMG
                           + 32'(col_q) + 32'(kc_q));
    assign act_s_c   = {1'b0, act_q};
    assign coef_s_c  = coef_data;
    assign prod_c    = act_s_c * coef_s_c;
    assign acc_sum_c = acc_q + ACC_W'(prod_c);
    assign last_c    = (filt_q == FW'(NFILT - 1)) && (row_q == OW'(OUT - 1))
                       && (col_q == OW'(OUT - 1));

`ifdef CONV_STAGE_RELU_EN
    assign res_c = acc_sum_c[ACC_W-1] ? '0 : acc_sum_c;
`else
    assign res_c = acc_sum_c;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        wr_pend_d   = rd_en_q;
        wr_addr_d   = rd_addr_q;
        coef_addr_d = coef_addr_q;
        kcnt_d      = kcnt_q;
        ch_d        = ch_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        tap_vld_d   = 1'b0;
        act_d       = act_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        filt_d      = filt_q;
        row_d       = row_q;
        col_d       = col_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            LOAD: begin
                if (rd_en_q && (rd_addr_q != AW'(NBUF - 1))) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                end
                if (wr_pend_q && (wr_addr_q == AW'(NBUF - 1))) begin
                    state_d     = MAC;
                    filt_d      = '0;
                    row_d       = '0;
                    col_d       = '0;
                    kcnt_d      = '0;
                    ch_d        = '0;
                    kr_d        = '0;
                    kc_d        = '0;
                    acc_d       = '0;
                    coef_addr_d = '0;
                end
            end
            MAC: begin
                if (tap_vld_q) acc_d = acc_sum_c;
                if (kcnt_q != KW'(NTAP)) begin
                    tap_vld_d = 1'b1;
                    act_d     = mem_q[act_idx_c];
                    kcnt_d    = kcnt_q + KW'(1);
                    // Coefficient addresses are consecutive across ch/kr/kc for one filter.
                    if (kcnt_q != KW'(NTAP - 1)) begin
                        coef_addr_d = coef_addr_q + CW'(1);
                        if (kc_q == 2'd2) begin
                            kc_d = 2'd0;
                            if (kr_q == 2'd2) begin
                                kr_d = 2'd0;
                                ch_d = ch_q + CHW'(1);
                            end else begin
                                kr_d = kr_q + 2'd1;
                            end
                        end else begin
                            kc_d = kc_q + 2'd1;
                        end
                    end
                end else begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = res_c;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_c) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        if (col_q == OW'(OUT - 1)) begin
                            col_d = '0;
                            if (row_q == OW'(OUT - 1)) begin
                                row_d  = '0;
                                filt_d = filt_q + FW'(1);
                            end else begin
                                row_d = row_q + OW'(1);
                            end
                        end else begin
                            col_d = col_q + OW'(1);
                        end
                        state_d     = MAC;
                        kcnt_d      = '0;
                        ch_d        = '0;
                        kr_d        = '0;
                        kc_d        = '0;
                        acc_d       = '0;
                        coef_addr_d = CW'(32'(filt_d) * NTAP);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            coef_addr_q <= '0;
            kcnt_q      <= '0;
            ch_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            tap_vld_q   <= 1'b0;
            act_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            filt_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            coef_addr_q <= coef_addr_d;
            kcnt_q      <= kcnt_d;
            ch_q        <= ch_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            tap_vld_q   <= tap_vld_d;
            act_q       <= act_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            filt_q      <= filt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            done_q      <= done_d;
        end
    end

    // Feature-map buffer survives reset; every job reloads it completely.
    always_ff @(posedge clk) begin
        if (wr_pend_q) mem_q[wr_addr_q] <= rd_data;
    end

    assign busy      = busy_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign coef_addr = coef_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_filt  = filt_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign done      = done_q;

endmodule

// File: doc/conv_stage_gen.md
CONV_STAGE_GEN -- requirements
Module: conv_stage_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 17, unsigned activation width read from BRAM.
REQ-002 SHALL have parameter COEF_W, default 17, signed filter coefficient width.
REQ-003 SHALL have parameter IMG, default 8, input feature-map side (IMG x IMG).
REQ-004 SHALL have parameter CH, default 3, input channel count.
REQ-005 SHALL have parameter NFILT, default 4, filter count; kernel fixed 3x3, stride 1, no padding, OUT = IMG-2.
REQ-006 SHALL derive ACC_W = DATA_W+1+COEF_W+clog2(9*CH) as a localparam.
REQ-007 SHALL have one clock and asynchronous active-high reset, ports named clk and reset.
REQ-008 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  one-cycle pulse: input BRAM filled
- busy  out  1  high from accepted start until done
- rd_en  out  1  activation BRAM read enable
- rd_addr  out  clog2(IMG*IMG*CH)  activation address
- rd_data  in  DATA_W  activation data, valid 1 cycle after rd_en
- coef_addr  out  clog2(NFILT*CH*9)  coefficient ROM address
- coef_data  in  COEF_W  signed coefficient, valid 1 cycle after coef_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  signed convolution result
- out_filt / out_row / out_col  out  clog2(NFILT) / clog2(OUT) / clog2(OUT)  result index
- done  out  1  one-cycle pulse after last result accepted

Function
REQ-009 SHALL implement FSM IDLE -> LOAD -> MAC -> EMIT -> (MAC | FIN) -> IDLE.
REQ-010 IDLE: start=1 moves to LOAD; start while not IDLE SHALL be ignored.
REQ-011 LOAD: rd_en=1 for IMG*IMG*CH consecutive cycles, rd_addr = (ch*IMG+row)*IMG+col ascending from 0; each rd_data written to internal buffer one cycle later; MAC entered the cycle after the last write.
REQ-012 rd_data SHALL be zero-extended by one bit before multiplication (unsigned activation x signed coefficient).
REQ-013 MAC: for current (f,r,c), coef_addr = ((f*CH+ch)*3+kr)*3+kc iterated ch, kr, kc ascending over 9*CH cycles; accumulator cleared at MAC entry; product of buffer[ch][r+kr][c+kc] and coef_data accumulated one cycle after each address.
REQ-014 Accumulation SHALL be full-precision in ACC_W bits; no overflow possible by construction.
REQ-015 out_valid SHALL rise exactly 9*CH+1 cycles after MAC entry (EMIT), holding out_data and indices stable until out_valid&&out_ready.
REQ-016 On handshake: next index in order f outermost, then r, then c; returns to MAC next cycle; after index (NFILT-1, OUT-1, OUT-1) goes to FIN.
REQ-017 FIN: done=1 for one cycle, busy falls same cycle, then IDLE.
REQ-018 out_ready held low SHALL stall indefinitely without data loss or change.
REQ-019 rd_en SHALL be 0 outside LOAD; coef_addr is don't-care outside MAC.

Reset
REQ-020 reset SHALL force IDLE immediately, at any state; busy, rd_en, out_valid, done = 0; rd_addr, coef_addr, out_data, indices, accumulator = 0.
REQ-021 Buffer contents are not cleared; a reset mid-LOAD or mid-MAC discards the job, and the next start reloads fully.

Configuration
REQ-022 Macro CONV_STAGE_RELU_EN defined: out_data = max(0, accumulator); undefined: out_data = raw signed accumulator; interface and timing identical either way.

Verification
REQ-023 Defaults, all activations 1, all coefficients 1, out_ready=1 -> 144 results, each 27, order f/r/c ascending, done once, busy low after.
REQ-024 Activation = col index, filter 0 coef 1 only at kr=1,kc=1,ch=0 -> filter-0 result (r,c) = c+1; first out_valid at 9*3+1 cycles after MAC entry.
REQ-025 out_ready toggled randomly / held low 50 cycles -> no dropped or duplicated results, out_data stable while stalled.
REQ-026 Coefficients all -1, activations 5 -> out_data = -135 without CONV_STAGE_RELU_EN, 0 with it.
REQ-027 start pulsed during MAC; reset asserted mid-LOAD -> extra start ignored; after reset all outputs 0, IDLE, new start produces correct 144 results.
REQ-028 Parameters IMG=6, CH=2, NFILT=2 -> 32 results, rd_addr 0..71, coef_addr 0..35, each value matches golden model.
